// File: rtl/truth_table_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_capture_pkg
// Purpose  : Shared types and constants for the truth-table capture engine:
//            FSM state encoding, default settle time and the table-width
//            derivation from the number of function inputs.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package truth_table_capture_pkg;

  localparam int unsigned DEFAULT_N_IN   = 3;
  localparam int unsigned DEFAULT_SETTLE = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Number of rows in the truth table of an n_in-input function.
  function automatic int unsigned table_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_capture_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_capture_settle_timer
// Purpose  : Load/count/terminal-count timer. While en_i is high the count
//            advances each cycle; tc_o flags the cycle in which the count has
//            reached SETTLE-1, and the count wraps to zero on that edge.
// Ports    : clk_i   - clock
//            rst_ni  - asynchronous active-low reset
//            load_i  - clear the count to zero
//            en_i    - count enable
//            tc_o    - terminal-count pulse (combinational, qualified by en_i)
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_capture_settle_timer #(
  parameter int unsigned SETTLE = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  // Count only needs to reach SETTLE-1; keep at least one bit for SETTLE=1.
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/truth_table_capture.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_capture
// Purpose  : Exhaustive stimulus/response engine for a small combinational
//            block. Drives input vectors 0..TW-1 in order, holds each for
//            SETTLE cycles, samples f_in_i in a single SAMPLE cycle and builds
//            a truth table that is compared with a latched expected table.
// Ports    : clk_i          - clock
//            rst_ni         - asynchronous active-low reset
//            start_i        - sweep request, honoured only when idle
//            expected_i     - expected table, latched on accepted start
//            f_in_i         - output of the block under test
//            x_out_o        - input vector to the block under test
//            busy_o         - sweep in progress
//            done_o         - one-cycle end-of-sweep pulse
//            pass_o         - captured table matched the expected table
//            table_out_o    - captured truth table
//            mismatch_cnt_o - number of differing table bits
//            first_fail_o   - lowest differing index (0 when passing)
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_capture
  import truth_table_capture_pkg::*;
#(
  parameter int unsigned N_IN   = DEFAULT_N_IN,
  parameter int unsigned SETTLE = DEFAULT_SETTLE,
  localparam int unsigned TW    = table_width(N_IN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [TW-1:0]   expected_i,
  input  logic            f_in_i,
  output logic [N_IN-1:0] x_out_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [TW-1:0]   table_out_o,
  output logic [N_IN:0]   mismatch_cnt_o,
  output logic [N_IN-1:0] first_fail_o
);

  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TW - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] x_out_q, x_out_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic [TW-1:0]   tbl_q, tbl_d;
  logic [N_IN:0]   mm_q, mm_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            pass_q, pass_d;

  logic            w_tc;
  logic            w_mismatch;
  logic            w_accept;

  assign w_accept   = (state_q == ST_IDLE) && start_i;
  assign w_mismatch = (f_in_i != exp_q[idx_q]);

  // Timer restarts on sweep acceptance and after every sample.
  truth_table_capture_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (w_accept || (state_q == ST_SAMPLE)),
    .en_i   (state_q == ST_SETTLE),
    .tc_o   (w_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_out_d = x_out_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    mm_d    = mm_q;
    ff_d    = ff_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE: begin
        x_out_d = '0;
        if (start_i) begin
          exp_d   = expected_i;
          tbl_d   = '0;
          mm_d    = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (w_tc) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        tbl_d[idx_q] = f_in_i;
        if (w_mismatch) begin
          mm_d = mm_q + 1'b1;
          // Only the first mismatch of the sweep records its index.
          if (mm_q == '0) begin
            ff_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          // Verdict is registered on entry to DONE so it is valid with done_o.
          pass_d  = (mm_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          x_out_d = idx_q + 1'b1;
          state_d = ST_SETTLE;
        end
      end

      ST_DONE: begin
        idx_d   = '0;
        x_out_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      x_out_q <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      mm_q    <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_out_q <= x_out_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  assign x_out_o        = x_out_q;
  assign busy_o         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done_o         = (state_q == ST_DONE);
  assign pass_o         = pass_q;
  assign table_out_o    = tbl_q;
  assign mismatch_cnt_o = mm_q;
  assign first_fail_o   = ff_q;

endmodule
`default_nettype wire

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Hardware stimulus-and-response engine for small combinational exercise blocks, such as 3-input single-output functions.
- Drives every input combination onto the block under test in ascending order and waits a programmable settle time per vector.
- Samples the block's output into a truth-table word and compares it against an expected table.
- Reports pass/fail, mismatch count and first failing index. This replaces hand-written exhaustive stimulus on the board or in system-level benches.

Parameters:
- N_IN, 3: number of function inputs; table width TW = 2**N_IN.
- SETTLE, 10: clock cycles the vector is held before sampling; legal range >= 1.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- expected  in  TW  expected table; bit i = f for input index i; latched on accepted start.
- f_in  in  1  output of the block under test; same clock domain, no synchronizer.
- x_out  out  N_IN  input vector to the block under test; x_out[N_IN-1] is x1 (MSB).
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of sweep.
- pass  out  1  1 when captured table equals latched expected; valid from done, held until next accepted start.
- table_out  out  TW  captured truth table; held until next accepted start.
- mismatch_cnt  out  N_IN+1  number of differing bits.
- first_fail  out  N_IN  lowest failing index; 0 when pass=1.

Behaviour:
- Reset (asynchronous, Resetn=0) sets all of the following:
  - state=IDLE, x_out=0, busy=0, done=0, pass=0;
  - table_out=0, mismatch_cnt=0, first_fail=0;
  - internal idx=0, settle count=0.
- Reset mid-sweep aborts immediately. No done pulse is produced, and results return to their reset values.
- FSM states are IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy=0, x_out=0.
  - On start=1 at an edge: latch expected; clear table_out, mismatch_cnt, first_fail and pass; set idx=0, x_out=0, count=0; go to SETTLE.
- SETTLE:
  - busy=1; count increments each edge.
  - At the edge where count==SETTLE-1, go to SAMPLE.
  - x_out is stable for the whole state.
- SAMPLE (one cycle):
  - At its closing edge, table_out[idx] <= f_in.
  - If f_in != expected_latched[idx]:
    - mismatch_cnt increments;
    - first_fail <= idx if this is the first mismatch of the sweep.
  - If idx == TW-1, go to DONE.
  - Otherwise idx <= idx+1, x_out <= idx+1, count <= 0, and go to SETTLE.
- DONE (one cycle):
  - done=1, busy=0, pass = (mismatch_cnt==0); return to IDLE.
  - x_out returns to 0 on the exit edge.
- Latency:
  - Each vector takes SETTLE+1 cycles.
  - done is high in the cycle beginning TW*(SETTLE+1) edges after the start edge.
  - Defaults: done 88 cycles after start.
- Boundary conditions:
  - start while busy or in DONE is ignored; it is neither queued nor restarts the sweep.
  - Changes on expected after acceptance have no effect.
  - idx wrap from TW-1 does not occur; the sweep ends.
  - mismatch_cnt saturates naturally at TW, which fits in N_IN+1 bits.
  - start in the cycle after done (IDLE) is accepted normally.
  - f_in is sampled only in SAMPLE; glitches during SETTLE are ignored.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - TW derivation;
  - default SETTLE.
- One natural sub-module is settle_timer: a load/count/terminal-count pulse counter parameterised by SETTLE, instantiated once.
- Comparator and bit-capture logic stay in the top module.

Test Plan:
- f_in tied to the 3-input majority of x_out, expected=8'hE8, start pulsed -> done 88 cycles after the start edge, pass=1, table_out=8'hE8, mismatch_cnt=0, first_fail=0.
- Same loopback, expected=8'hE9 -> pass=0, table_out=8'hE8, mismatch_cnt=1, first_fail=0.
- f_in=1 constant, expected=8'h00 -> table_out=8'hFF, mismatch_cnt=8, first_fail=0, pass=0.
- Majority loopback with SETTLE=1 -> x_out steps 0..7 every 2 cycles, done 16 cycles after start, pass=1.
- start re-pulsed at cycles 5 and 40 of a sweep -> ignored; single done at cycle 88. Then Resetn low at cycle 30 of a new sweep -> x_out=0, busy=0, table_out=0 immediately, no done.
- Check that x_out never changes during SETTLE, and that f_in toggled mid-SETTLE does not affect table_out.
